// File: rtl/m_bpred.sv
// m_bpred: direct-mapped BTB with 2-bit counters plus branch/mispredict event counters
module m_bpred #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic [31:0] w_pc,
  output logic        w_bp_tkn,
  output logic [31:0] w_ppc,
  input  logic        w_upd_v,
  input  logic [31:0] w_upd_pc,
  input  logic        w_upd_tkn,
  input  logic [31:0] w_upd_tpc,
  input  logic        w_miss,
  output logic [31:0] w_nbr,
  output logic [31:0] w_nmis
);
  localparam int TAG_W = 30 - IDX_W;
  logic             r_vld [ENTRIES];
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [31:0]      r_tgt [ENTRIES];
  logic [1:0]       r_ctr [ENTRIES];
  logic [IDX_W-1:0] w_idx, w_uidx;
  logic [TAG_W-1:0] w_tag, w_utag;
  logic             w_hit, w_uhit;
  logic             w_unused;
  assign w_unused = &{1'b0, w_pc[1:0], w_upd_pc[1:0]};
  always_comb begin
    w_idx    = w_pc[IDX_W+1:2];
    w_tag    = w_pc[31:IDX_W+2];
    w_uidx   = w_upd_pc[IDX_W+1:2];
    w_utag   = w_upd_pc[31:IDX_W+2];
    w_hit    = r_vld[w_idx] && r_tag[w_idx] == w_tag;
    w_uhit   = r_vld[w_uidx] && r_tag[w_uidx] == w_utag;
    w_bp_tkn = w_hit & r_ctr[w_idx][1];
    w_ppc    = w_bp_tkn ? r_tgt[w_idx] : w_pc + 32'd4;
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_ctr[i] <= 2'b01;
      end
      w_nbr  <= '0;
      w_nmis <= '0;
    end else begin
      if (w_upd_v) w_nbr <= w_nbr + 32'd1;
      if (w_miss) w_nmis <= w_nmis + 32'd1;
      if (w_upd_v && w_uhit) begin
        r_ctr[w_uidx] <= w_upd_tkn ? (r_ctr[w_uidx] == 2'b11 ? 2'b11 : r_ctr[w_uidx] + 2'b01)
                                   : (r_ctr[w_uidx] == 2'b00 ? 2'b00 : r_ctr[w_uidx] - 2'b01);
        if (w_upd_tkn) r_tgt[w_uidx] <= w_upd_tpc;
      end else if (w_upd_v && w_upd_tkn) begin
        // a taken miss claims the slot, evicting whatever alias lived there
        r_vld[w_uidx] <= 1'b1;
        r_tag[w_uidx] <= w_utag;
        r_tgt[w_uidx] <= w_upd_tpc;
        r_ctr[w_uidx] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_m_bpred.sv
// tb_m_bpred: directed self-checking bench for m_bpred
module tb_m_bpred;
  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [31:0] w_pc = '0;
  logic        w_bp_tkn;
  logic [31:0] w_ppc;
  logic        w_upd_v = 1'b0;
  logic [31:0] w_upd_pc = '0;
  logic        w_upd_tkn = 1'b0;
  logic [31:0] w_upd_tpc = '0;
  logic        w_miss = 1'b0;
  logic [31:0] w_nbr, w_nmis;
  int n_tests = 0;
  int n_fail = 0;
  m_bpred dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_pc(w_pc), .w_bp_tkn(w_bp_tkn), .w_ppc(w_ppc),
    .w_upd_v(w_upd_v), .w_upd_pc(w_upd_pc), .w_upd_tkn(w_upd_tkn), .w_upd_tpc(w_upd_tpc),
    .w_miss(w_miss), .w_nbr(w_nbr), .w_nmis(w_nmis)
  );
  always #5 w_clk = ~w_clk;
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask
  task automatic do_reset();
    w_rst = 1'b1;
    tick();
    tick();
    w_rst = 1'b0;
  endtask
  task automatic upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tpc);
    w_upd_v = 1'b1;
    w_upd_pc = pc;
    w_upd_tkn = tkn;
    w_upd_tpc = tpc;
    tick();
    w_upd_v = 1'b0;
  endtask
  task automatic look(input logic [31:0] pc);
    w_pc = pc;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({w_nbr, w_nmis} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_cnt nbr=%0d nmis=%0d want 0 0", w_nbr, w_nmis);
    end
    for (int a = 0; a <= 32'h3C; a += 4) begin
      look(a);
      n_tests++;
      if ({w_bp_tkn, w_ppc} !== {1'b0, a + 32'd4}) begin
        n_fail++;
        $display("FAIL reset_sweep pc=%h got tkn=%b ppc=%h want tkn=0 ppc=%h", a, w_bp_tkn, w_ppc, a + 4);
      end
    end
  endtask
  task automatic test_cold_alloc();
    w_upd_v = 1'b1;
    w_upd_pc = 32'h14;
    w_upd_tkn = 1'b1;
    w_upd_tpc = 32'hC;
    look(32'h14);
    n_tests++;
    if (w_bp_tkn !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle got tkn=%b want 0", w_bp_tkn);
    end
    tick();
    w_upd_v = 1'b0;
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL cold_alloc got tkn=%b ppc=%h want 1 0000000c", w_bp_tkn, w_ppc);
    end
    n_tests++;
    if (w_nbr !== 32'd1) begin
      n_fail++;
      $display("FAIL cold_nbr got %0d want 1", w_nbr);
    end
  endtask
  task automatic test_hysteresis();
    for (int k = 0; k < 3; k++) upd(32'h14, 1'b1, 32'hC);
    upd(32'h14, 1'b0, 32'h0);
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL hyst_sat3 got tkn=%b ppc=%h want 1 0000000c", w_bp_tkn, w_ppc);
    end
    upd(32'h14, 1'b0, 32'h0);
    upd(32'h14, 1'b0, 32'h0);
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h18}) begin
      n_fail++;
      $display("FAIL hyst_zero got tkn=%b ppc=%h want 0 00000018", w_bp_tkn, w_ppc);
    end
    upd(32'h14, 1'b0, 32'h0);
    upd(32'h14, 1'b1, 32'hC);
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h18}) begin
      n_fail++;
      $display("FAIL hyst_sat0 got tkn=%b ppc=%h want 0 00000018", w_bp_tkn, w_ppc);
    end
    n_tests++;
    if (w_nbr !== 32'd9) begin
      n_fail++;
      $display("FAIL hyst_nbr got %0d want 9", w_nbr);
    end
  endtask
  task automatic test_alias();
    do_reset();
    upd(32'h14, 1'b1, 32'hC);
    look(32'h54);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h58}) begin
      n_fail++;
      $display("FAIL alias_tag got tkn=%b ppc=%h want 0 00000058", w_bp_tkn, w_ppc);
    end
    upd(32'h54, 1'b1, 32'h100);
    look(32'h54);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL alias_new got tkn=%b ppc=%h want 1 00000100", w_bp_tkn, w_ppc);
    end
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h18}) begin
      n_fail++;
      $display("FAIL alias_evict got tkn=%b ppc=%h want 0 00000018", w_bp_tkn, w_ppc);
    end
    look(32'h80000054);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h80000058}) begin
      n_fail++;
      $display("FAIL alias_msb got tkn=%b ppc=%h want 0 80000058", w_bp_tkn, w_ppc);
    end
    upd(32'h54, 1'b1, 32'h200);
    look(32'h57);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL tgt_update got tkn=%b ppc=%h want 1 00000200", w_bp_tkn, w_ppc);
    end
    look(32'hFFFFFFFC);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL pc_wrap got tkn=%b ppc=%h want 0 00000000", w_bp_tkn, w_ppc);
    end
  endtask
  task automatic test_nt_miss();
    upd(32'h20, 1'b0, 32'h40);
    look(32'h20);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h24}) begin
      n_fail++;
      $display("FAIL nt_noalloc got tkn=%b ppc=%h want 0 00000024", w_bp_tkn, w_ppc);
    end
    upd(32'h20, 1'b1, 32'h40);
    look(32'h20);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL nt_alloc got tkn=%b ppc=%h want 1 00000040", w_bp_tkn, w_ppc);
    end
    upd(32'h20, 1'b0, 32'h0);
    look(32'h20);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h24}) begin
      n_fail++;
      $display("FAIL alloc_ctr2 got tkn=%b ppc=%h want 0 00000024", w_bp_tkn, w_ppc);
    end
  endtask
  task automatic test_counters();
    do_reset();
    upd(32'h14, 1'b1, 32'hC);
    w_miss = 1'b1;
    upd(32'h30, 1'b0, 32'h0);
    w_miss = 1'b0;
    upd(32'h30, 1'b0, 32'h0);
    w_miss = 1'b1;
    tick();
    w_miss = 1'b0;
    upd(32'h34, 1'b0, 32'h0);
    upd(32'h38, 1'b0, 32'h0);
    n_tests++;
    if ({w_nbr, w_nmis} !== {32'd5, 32'd2}) begin
      n_fail++;
      $display("FAIL counters got nbr=%0d nmis=%0d want 5 2", w_nbr, w_nmis);
    end
    look(32'h14);
    n_tests++;
    if (w_bp_tkn !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst got tkn=%b want 1", w_bp_tkn);
    end
    w_rst = 1'b1;
    w_miss = 1'b1;
    upd(32'h14, 1'b1, 32'hC);
    w_rst = 1'b0;
    w_miss = 1'b0;
    n_tests++;
    if ({w_nbr, w_nmis} !== 64'd0) begin
      n_fail++;
      $display("FAIL rst_prio_cnt got nbr=%0d nmis=%0d want 0 0", w_nbr, w_nmis);
    end
    look(32'h14);
    n_tests++;
    if ({w_bp_tkn, w_ppc} !== {1'b0, 32'h18}) begin
      n_fail++;
      $display("FAIL rst_prio_btb got tkn=%b ppc=%h want 0 00000018", w_bp_tkn, w_ppc);
    end
  endtask
  initial begin
    test_reset();
    test_cold_alloc();
    test_hysteresis();
    test_alias();
    test_nt_miss();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
